otter_mem_arbiter: RTL and testbench

Shares one downstream OTTER memory port (the port feeding the OTTER-to-AXI translator) between `NUM_REQ` OTTER-style requesters, e.g. simulation/boot memory initialiser, instruction fetch and data access. Grants one whole transaction at a time using round-robin priority. The granted request is latched into registers, so downstream signals stay stable for the whole transaction. A watchdog flags transactions that never complete.

---
 rtl/otter_arb_pkg.sv | 16 +
 rtl/otter_mem_arbiter_rr_pick.sv | 27 ++
 rtl/otter_mem_arbiter.sv | 102 ++++++++++
 tb/tb_otter_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_arb_pkg.sv
// otter_arb_pkg: shared types for the OTTER memory arbiter.
// Provides the FSM state enum, the memory size encoding and the latched request struct.
package otter_arb_pkg;
  typedef enum logic {IDLE, BUSY} arb_state_t;
  typedef logic [1:0] mem_size_t;
  localparam mem_size_t SZ_BYTE = 2'd0;
  localparam mem_size_t SZ_HALF = 2'd1;
  localparam mem_size_t SZ_WORD = 2'd2;
  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] addr;
    logic [31:0] din;
    mem_size_t   size;
  } otter_req_t;
endpackage

// File: rtl/otter_mem_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker (rotate, priority-encode, un-rotate).
// Ports: active - request vector; ptr - highest-priority index;
//        valid - any request active; idx - winning index.
module rr_pick #(
  parameter int NUM_REQ = 3,
  localparam int W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] active,
  input  logic [W-1:0]       ptr,
  output logic               valid,
  output logic [W-1:0]       idx
);
  logic [NUM_REQ-1:0] w_rot;
  logic [W-1:0]       w_ofs;
  logic [W:0]         w_sum;
  // Rotate so that bit 0 is the requester at ptr.
  assign w_rot = NUM_REQ'({active, active} >> ptr);
  always_comb begin
    w_ofs = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (w_rot[k]) w_ofs = W'(k);
  end
  // Un-rotate with a modulo add; ptr and w_ofs are both below NUM_REQ.
  assign w_sum = {1'b0, w_ofs} + {1'b0, ptr};
  assign idx   = (w_sum >= (W+1)'(NUM_REQ)) ? W'(w_sum - (W+1)'(NUM_REQ)) : W'(w_sum);
  assign valid = |active;
endmodule

// File: rtl/otter_mem_arbiter.sv
// otter_mem_arbiter: round-robin arbiter sharing one OTTER memory port among NUM_REQ requesters.
// Ports: clk/rst_n - clock and async active-low reset;
//        req_* - per-requester read/write/addr/din/size in, stall out, shared dout;
//        ds_* - downstream request out, read data and stall in;
//        grant/busy - current owner and busy state; timeout_err - sticky watchdog flag.
module otter_mem_arbiter
  import otter_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int TIMEOUT = 1024,
  localparam int GW = $clog2(NUM_REQ),
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_read,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ-1:0][31:0]  req_addr,
  input  logic [NUM_REQ-1:0][31:0]  req_din,
  input  logic [NUM_REQ-1:0][1:0]   req_size,
  output logic [NUM_REQ-1:0]        req_stall,
  output logic [31:0]               req_dout,
  output logic                      ds_read,
  output logic                      ds_write,
  output logic [31:0]               ds_addr,
  output logic [31:0]               ds_din,
  output logic [1:0]                ds_size,
  input  logic [31:0]               ds_dout,
  input  logic                      ds_stall,
  output logic [GW-1:0]             grant,
  output logic                      busy,
  output logic                      timeout_err
);
  arb_state_t         r_state;
  otter_req_t         r_req;
  logic [GW-1:0]      r_grant;
  logic [GW-1:0]      r_ptr;
  logic [TW-1:0]      r_cnt;
  logic               r_err;
  logic [NUM_REQ-1:0] w_active;
  logic               w_valid;
  logic [GW-1:0]      w_idx;
  logic [TW-1:0]      w_cnt_nxt;

  assign w_active = req_read | req_write;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .active(w_active),
    .ptr   (r_ptr),
    .valid (w_valid),
    .idx   (w_idx)
  );

  // Watchdog saturates at TIMEOUT instead of wrapping.
  assign w_cnt_nxt = (r_cnt == TW'(TIMEOUT)) ? r_cnt : r_cnt + TW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_req   <= '0;
      r_grant <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_cnt <= (r_state == BUSY) ? w_cnt_nxt : '0;
      if (r_state == BUSY && TIMEOUT != 0 && w_cnt_nxt == TW'(TIMEOUT)) r_err <= 1'b1;
      if (r_state == IDLE) begin
        if (w_valid) begin
          r_state <= BUSY;
          r_grant <= w_idx;
          // Write wins when a requester raises both strobes.
          r_req   <= '{read:  req_read[w_idx] & ~req_write[w_idx],
                       write: req_write[w_idx],
                       addr:  req_addr[w_idx],
                       din:   req_din[w_idx],
                       size:  mem_size_t'(req_size[w_idx])};
        end
      end else if (!ds_stall) begin
        r_state     <= IDLE;
        r_ptr       <= (r_grant == GW'(NUM_REQ - 1)) ? '0 : r_grant + GW'(1);
        r_req.read  <= 1'b0;
        r_req.write <= 1'b0;
      end
    end
  end

  // Stall drops only for the owner in its completion cycle.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stall
    assign req_stall[i] = w_active[i] & ~(busy & (r_grant == GW'(i)) & ~ds_stall);
  end

  assign busy        = (r_state == BUSY);
  assign grant       = r_grant;
  assign ds_read     = r_req.read;
  assign ds_write    = r_req.write;
  assign ds_addr     = r_req.addr;
  assign ds_din      = r_req.din;
  assign ds_size     = r_req.size;
  assign req_dout    = ds_dout;
  assign timeout_err = r_err;
endmodule

// File: tb/tb_otter_mem_arbiter.sv
// tb_otter_mem_arbiter: directed and randomized checks of otter_mem_arbiter against a transaction-level model.
module tb_otter_mem_arbiter;
  localparam int N  = 3;
  localparam int TO = 8;
  localparam int GW = $clog2(N);

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [N-1:0]       req_read = '0;
  logic [N-1:0]       req_write = '0;
  logic [N-1:0][31:0] req_addr = '0;
  logic [N-1:0][31:0] req_din = '0;
  logic [N-1:0][1:0]  req_size = '0;
  logic [N-1:0]       req_stall;
  logic [31:0]        req_dout;
  logic               ds_read, ds_write;
  logic [31:0]        ds_addr, ds_din;
  logic [1:0]         ds_size;
  logic [31:0]        ds_dout = '0;
  logic               ds_stall = 1'b0;
  logic [GW-1:0]      grant;
  logic               busy, timeout_err;

  int checks = 0;
  int errors = 0;

  // Transaction-level reference: who owns the port, what was captured, how long it has run.
  bit          m_busy, m_rd, m_wr, m_err;
  int          m_owner, m_ptr, m_cnt, m_bcyc;
  logic [31:0] m_addr, m_din;
  logic [1:0]  m_size;
  int          lat = 1;
  int          lat_cfg = 0;
  int          done = -1;
  int          ds_wcyc = 0;
  int          grants[$];

  always #5 clk = ~clk;

  otter_mem_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_read(req_read), .req_write(req_write), .req_addr(req_addr),
    .req_din(req_din), .req_size(req_size), .req_stall(req_stall),
    .req_dout(req_dout), .ds_read(ds_read), .ds_write(ds_write),
    .ds_addr(ds_addr), .ds_din(ds_din), .ds_size(ds_size),
    .ds_dout(ds_dout), .ds_stall(ds_stall), .grant(grant),
    .busy(busy), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_rd = 0; m_wr = 0; m_err = 0;
    m_owner = 0; m_ptr = 0; m_cnt = 0; m_bcyc = 0;
    m_addr = '0; m_din = '0; m_size = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req_read = '0;
    req_write = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive downstream, check combinational outputs, advance model, check registered outputs.
  task automatic step();
    logic [N-1:0] act;
    int w;
    bit granted;
    done = -1;
    granted = 0;
    ds_stall = m_busy && (m_bcyc < lat - 1);
    ds_dout = $urandom;
    #1;
    act = req_read | req_write;
    for (int i = 0; i < N; i++)
      chk($sformatf("stall%0d", i), req_stall[i], act[i] & ~(m_busy & (m_owner == i) & ~ds_stall));
    chk("req_dout", req_dout, ds_dout);
    @(posedge clk);
    if (m_busy) m_cnt = (m_cnt < TO) ? m_cnt + 1 : TO;
    else m_cnt = 0;
    if (m_cnt == TO) m_err = 1;
    if (!m_busy) begin
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && act[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      if (w >= 0) begin
        m_busy = 1; m_owner = w; m_bcyc = 0; granted = 1;
        m_wr = req_write[w];
        m_rd = req_read[w] & ~req_write[w];
        m_addr = req_addr[w]; m_din = req_din[w]; m_size = req_size[w];
        lat = (lat_cfg > 0) ? lat_cfg : int'($urandom_range(1, 4));
      end
    end else if (!ds_stall) begin
      m_busy = 0; m_rd = 0; m_wr = 0;
      m_ptr = (m_owner + 1) % N;
      done = m_owner;
    end else m_bcyc++;
    @(negedge clk);
    if (granted) grants.push_back(int'(grant));
    if (ds_write) ds_wcyc++;
    chk("busy", busy, m_busy);
    chk("grant", grant, m_owner);
    chk("ds_read", ds_read, m_rd);
    chk("ds_write", ds_write, m_wr);
    chk("ds_addr", ds_addr, m_addr);
    chk("ds_din", ds_din, m_din);
    chk("ds_size", ds_size, m_size);
    chk("timeout_err", timeout_err, m_err);
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      step();
      if (done >= 0) begin
        req_read[done] = 1'b0;
        req_write[done] = 1'b0;
      end
    end
  endtask

  initial begin
    model_reset();
    req_read[0] = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_ds_read", ds_read, 0);
    chk("rst_ds_write", ds_write, 0);
    chk("rst_ds_addr", ds_addr, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_stall0", req_stall[0], 1);
    apply_reset();

    // Single requester write, downstream takes 3 busy cycles.
    lat_cfg = 3;
    ds_wcyc = 0;
    req_write[0] = 1'b1; req_addr[0] = 32'h100; req_din[0] = 32'hDEADBEEF; req_size[0] = 2'd2;
    run(6);
    chk("t1_wcycles", ds_wcyc, 3);
    req_read[0] = 1'b1; req_read[1] = 1'b1;
    run(1);
    chk("t1_ptr_moved", grant, 1);
    run(10);

    // Fairness: three readers always active.
    apply_reset();
    lat_cfg = 0;
    grants.delete();
    req_read = '1;
    for (int c = 0; c < 60 && grants.size() < 6; c++) step();
    chk("rr_count", grants.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < grants.size()) chk($sformatf("rr_order%0d", i), grants[i], i % 3);
    run(20);

    // Read and write together: write wins.
    apply_reset();
    lat_cfg = 2;
    req_read[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 32'h200; req_din[1] = $urandom;
    run(1);
    chk("conf_write", ds_write, 1);
    chk("conf_read", ds_read, 0);
    run(4);

    // Address change while granted is ignored.
    apply_reset();
    lat_cfg = 4;
    req_read[2] = 1'b1; req_addr[2] = 32'h40;
    run(1);
    req_addr[2] = 32'h80;
    repeat (3) begin
      chk("mid_addr", ds_addr, 32'h40);
      run(1);
    end
    run(3);

    // Randomized traffic.
    apply_reset();
    lat_cfg = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(req_read[i] | req_write[i]) || done == i) begin
          if ($urandom_range(0, 2) == 0) begin
            logic [1:0] v;
            v = 2'($urandom_range(1, 3));
            req_read[i] = v[0]; req_write[i] = v[1];
            req_addr[i] = $urandom; req_din[i] = $urandom;
            req_size[i] = 2'($urandom_range(0, 2));
          end else begin
            req_read[i] = 1'b0; req_write[i] = 1'b0;
          end
        end else if (m_busy && m_owner == i && $urandom_range(0, 3) == 0) begin
          req_addr[i] = $urandom;
          req_din[i] = $urandom;
        end
      end
      step();
    end

    // Watchdog with a downstream that stalls for 12 cycles.
    apply_reset();
    lat_cfg = 12;
    req_read[0] = 1'b1; req_addr[0] = 32'h300;
    run(1);
    run(7);
    chk("wd_early", timeout_err, 0);
    run(1);
    chk("wd_set", timeout_err, 1);
    run(10);
    chk("wd_sticky", timeout_err, 1);
    chk("wd_done", busy, 0);

    // Asynchronous reset during a transaction.
    lat_cfg = 12;
    req_write[1] = 1'b1; req_addr[1] = 32'h500; req_din[1] = $urandom;
    run(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_ds_write", ds_write, 0);
    chk("ar_ds_read", ds_read, 0);
    chk("ar_busy", busy, 0);
    chk("ar_grant", grant, 0);
    chk("ar_timeout", timeout_err, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    lat_cfg = 2;
    run(1);
    chk("ar_regrant", grant, 1);
    chk("ar_rewrite", ds_write, 1);
    run(4);
    chk("ar_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
